// File: rtl/digit_serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the FSM state type, the per-bit cell and digit-count helpers.
package digit_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_digits(
        input int size,
        input int digit
    );
        return size / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns {cout, sum}; the approximate cell drops the incoming carry
    function automatic logic [1:0] sub_cell(
        input logic a,
        input logic bn,
        input logic cin,
        input logic approx
    );
        logic [1:0] r;
        if (approx) begin
            r = {a & bn, a ^ bn};
        end else begin
            r = {(a & bn) | (cin & (a ^ bn)), a ^ bn ^ cin};
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_sub_if.sv
// Operand/result handshake bundle of the digit-serial subtractor.
// master drives operands and out_ready, slave is the subtractor.
interface digit_serial_sub_if #(
    parameter int SIZE = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            approx_en;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] diff;
    logic            borrow;
    logic            overflow;

    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/digit_serial_sub_slice.sv
// Combinational ripple chain of DIGIT subtractor cells.
// Each bit picks the exact or carry-ignore cell from i_mask.
module sub_digit_slice
    import digit_serial_sub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_bn,
    input  logic [DIGIT-1:0] i_mask,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);
    logic       w_c;
    logic [1:0] w_r;

    always_comb begin
        o_sum = '0;
        w_r   = '0;
        w_c   = i_cin;
        for (int j = 0; j < DIGIT; j++) begin
            w_r      = sub_cell(i_a[j], i_bn[j], w_c, i_mask[j]);
            o_sum[j] = w_r[0];
            w_c      = w_r[1];
        end
        o_cout = w_c;
    end
endmodule

// File: rtl/digit_serial_sub.sv
// Digit-serial signed subtractor a - b, LSB digit first.
// Low APPROX_BITS may use the carry-ignore cell when approx_en is captured.
module digit_serial_sub
    import digit_serial_sub_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int DIGIT       = 4,
    parameter int APPROX_BITS = 0
) (
    input logic               clk,
    input logic               rst_n,
    digit_serial_sub_if.slave bus
);
    localparam int N  = num_digits(SIZE, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          r_state;
    state_t          w_next;
    logic            r_alive;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_bn;
    logic [SIZE-1:0] r_diff;
    logic            r_apx;
    logic            r_carry;
    logic            r_borrow;
    logic            r_ovf;
    logic            r_a_msb;
    logic            r_b_msb;
    logic [CW-1:0]   r_cnt;

    logic [DIGIT-1:0] w_mask;
    logic [DIGIT-1:0] w_sum;
    logic [SIZE-1:0]  w_diff_nxt;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)      w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = r_alive && (r_state == IDLE);
        w_out_valid = (r_state == DONE);
    end

    // Holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_alive <= 1'b0;
        else        r_alive <= 1'b1;
    end

    assign w_accept = bus.in_valid & w_in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST);

    always_comb begin
        w_mask = '0;
        for (int j = 0; j < DIGIT; j++) begin
            w_mask[j] = r_apx &&
                ((int'(r_cnt) * DIGIT + j) < APPROX_BITS);
        end
    end

    sub_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a    (r_a[DIGIT-1:0]),
        .i_bn   (r_bn[DIGIT-1:0]),
        .i_mask (w_mask),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    generate
        if (DIGIT == SIZE) begin : g_one
            assign w_diff_nxt = w_sum;
        end else begin : g_multi
            assign w_diff_nxt = {w_sum, r_diff[SIZE-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_bn     <= '0;
            r_diff   <= '0;
            r_apx    <= 1'b0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_bn    <= ~bus.b;
            r_apx   <= bus.approx_en;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_a_msb <= bus.a[SIZE-1];
            r_b_msb <= bus.b[SIZE-1];
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_bn    <= r_bn >> DIGIT;
            r_diff  <= w_diff_nxt;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_borrow <= ~w_cout;
                r_ovf    <= (r_a_msb != r_b_msb) &&
                            (w_sum[DIGIT-1] != r_a_msb);
            end
        end
    end

    // Result is masked outside DONE so partial digits never leak
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.diff      = w_out_valid ? r_diff : '0;
    assign bus.borrow    = w_out_valid & r_borrow;
    assign bus.overflow  = w_out_valid & r_ovf;
endmodule

// File: doc/digit_serial_sub.md
Name: digit_serial_sub

Overview:
- Multi-cycle, digit-serial signed subtractor computing diff = a - b, LSB digit first, DIGIT bits per cycle.
- Arithmetic is a + ~b + 1, with a registered carry between digits.
- Low APPROX_BITS use a carry-ignore approximate cell when approx_en is set. Remaining bits are exact.
- Sits beside the parallel adder trees in the DCT datapath for area-constrained difference terms. Valid/ready on both sides.

Parameters:
- SIZE, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= SIZE.
- APPROX_BITS, 0, number of LSBs eligible for approximation; 0 <= APPROX_BITS <= SIZE.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  SIZE  signed minuend
- b  input  SIZE  signed subtrahend
- approx_en  input  1  enable approximation for this operation
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  SIZE  signed result
- borrow  output  1  unsigned borrow = NOT final carry
- overflow  output  1  signed overflow of a - b

Behaviour:
- Reset values (async, on rst_n=0): state=IDLE, in_ready=0 while in reset and 1 on the first cycle after release, out_valid=0, diff=0, borrow=0, overflow=0, digit counter=0, carry=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, ~b and approx_en into shift registers, set carry=1 and counter=0, then go to RUN.
  - RUN: in_ready=0. Each cycle process digit counter. Shift the DIGIT result bits into the result register from the MSB side, update carry and increment the counter. After digit N-1 (N=SIZE/DIGIT) go to DONE.
  - DONE: out_valid=1, and diff/borrow/overflow are valid and held stable. On out_ready go to IDLE and drop out_valid the next cycle.
- Latency: accept edge, then N RUN cycles, then out_valid asserted. With SIZE=16 and DIGIT=4, out_valid rises 4 cycles after the accept edge.
- Throughput: one operation per N+2 cycles minimum. in_ready is 0 in RUN and DONE, so there is no overlap.
- Per-bit cell at global bit index i (bn = ~b):
  - Exact cell: sum = a^bn^c, cout = a&bn | c&(a^bn).
  - Approximate cell, used when i < APPROX_BITS and the captured approx_en=1: sum = a^bn, cout = a&bn. Incoming carry is ignored, including the initial +1 at bit 0.
  - The approximate region may span multiple digits; the cell choice is per global bit.
- borrow = ~carry after the last digit.
- overflow = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]), evaluated on the produced (possibly approximate) diff.
- Inputs a, b and approx_en are ignored outside the accept cycle; changing them during RUN has no effect.
- Backpressure: DONE is held indefinitely while out_ready=0. Outputs do not change.
- in_valid during RUN or DONE is not accepted; the producer must hold it.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No partial result is ever presented.
- DIGIT=SIZE degenerates to N=1: one RUN cycle.

Decomposition:
- Package digit_serial_sub_pkg:
  - state enum (IDLE, RUN, DONE);
  - function sub_cell(a, bn, cin, approx) returning {cout, sum};
  - localparam helper for N = SIZE/DIGIT and the counter width $clog2(N) (minimum 1).
- One sub-module, sub_digit_slice #(DIGIT): combinational ripple chain of DIGIT cells. It takes a per-bit approx mask, digit inputs and cin, and produces the digit sum and cout. The top computes the mask from counter, APPROX_BITS and approx_en.

Test Plan:
- SIZE=16, DIGIT=4, APPROX_BITS=0; a=100, b=30 -> diff=70, borrow=0, overflow=0; out_valid exactly 4 cycles after accept.
- a=0, b=1 -> diff=16'hFFFF, borrow=1, overflow=0. Then a=-32768, b=1 -> diff=32767, borrow=0, overflow=1.
- APPROX_BITS=4, approx_en=1, a=16'h0003, b=16'h0001 -> diff=16'hFFFD (exact result would be 2). Same operands with approx_en=0 -> diff=2.
- Hold out_ready=0 for 5 cycles in DONE -> diff stable, out_valid stays 1, in_ready=0, extra in_valid ignored. Raise out_ready -> IDLE next cycle, and the next operand is accepted.
- Assert rst_n=0 during the second RUN cycle -> all outputs 0 asynchronously. After release, in_ready=1 and a new operation (a=5, b=7 -> diff=-2, borrow=1) completes correctly.
- Sweep 1000 random a, b with APPROX_BITS=0 against a reference model of a-b, borrow and overflow, with random out_ready backpressure -> zero mismatches.
